// File: rtl/mem_wr_port_arbiter_pkg.sv
// Shared widths, MCB command codes, arbiter state encoding and write payload type.
package mem_wr_port_arbiter_pkg;

  localparam int unsigned ADDR_W  = 30;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MASK_W  = 4;
  localparam int unsigned INSTR_W = 3;
  localparam int unsigned BL_W    = 6;
  localparam int unsigned CNT_W   = 10;

  // MCB command opcodes; this port only ever issues writes.
  typedef enum logic [INSTR_W-1:0] {
    MEM_CMD_WRITE = 3'b000,
    MEM_CMD_READ  = 3'b001
  } mem_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PUSH_D = 3'd1,
    ST_PUSH_C = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } arb_state_e;

  // One client write as latched at grant time.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } wr_payload_t;

endpackage

// File: rtl/mem_wr_port_arbiter_rr_pick.sv
// Round-robin picker: first set request searching upward from last+1, wrapping.
module mem_wr_port_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   grant_o
);

  // Walk offsets from farthest to nearest so the nearest set request wins.
  always_comb begin
    int unsigned cand;
    valid_o = 1'b0;
    grant_o = '0;
    cand    = 0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      cand = 32'(last_i) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (req_i[IDX_W'(cand)]) begin
        valid_o = 1'b1;
        grant_o = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_wr_port_arbiter.sv
// Shares one MCB write-only port among NUM_REQ single-word write clients.
// Each grant pushes the data word, then the command, waits for both MCB
// FIFOs to drain (or times out), then pulses the granted client's done.
module mem_wr_port_arbiter
  import mem_wr_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 1023  // must fit the 10-bit drain counter
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      calib_done,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  input  logic [MASK_W*NUM_REQ-1:0] req_mask,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic                      mem_cmd_en,
  output logic [INSTR_W-1:0]        mem_cmd_instr,
  output logic [BL_W-1:0]           mem_cmd_bl,
  output logic [ADDR_W-1:0]         mem_cmd_byte_addr,
  input  logic                      mem_cmd_empty,
  input  logic                      mem_cmd_full,
  output logic                      mem_wr_en,
  output logic [MASK_W-1:0]         mem_wr_mask,
  output logic [DATA_W-1:0]         mem_wr_data,
  input  logic                      mem_wr_empty,
  input  logic                      mem_wr_full,
  input  logic                      mem_wr_underrun,
  input  logic                      mem_wr_error
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e          state_q;
  logic [IDX_W-1:0]    last_q;
  logic [IDX_W-1:0]    grant_q;
  wr_payload_t         pay_q;
  logic [NUM_REQ-1:0]  done_q;
  logic                err_q;
  logic                wr_en_q;
  logic                cmd_en_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  wr_payload_t         sel_pay_c;
  logic                drained_c;
  logic                timeout_c;

  mem_wr_port_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i   (req),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .grant_o (pick_idx)
  );

  // Mux out the payload of the client the picker selected.
  always_comb begin
    sel_pay_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_pay_c.addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_pay_c.data = req_data[i*DATA_W +: DATA_W];
        sel_pay_c.mask = req_mask[i*MASK_W +: MASK_W];
      end
    end
  end

  // The cycle cmd_en is high the MCB has not yet taken the command, so its
  // empty flag is stale; only trust the FIFO flags once the push has landed.
  always_comb begin
    drained_c = !cmd_en_q && mem_cmd_empty && mem_wr_empty;
    timeout_c = (state_q == ST_DRAIN) && !drained_c &&
                (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  // Grant FSM with registered MCB strobes and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      last_q   <= IDX_W'(NUM_REQ - 1);
      grant_q  <= '0;
      pay_q    <= '0;
      done_q   <= '0;
      wr_en_q  <= 1'b0;
      cmd_en_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      done_q   <= '0;
      wr_en_q  <= 1'b0;
      cmd_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (calib_done && pick_valid) begin
            grant_q <= pick_idx;
            last_q  <= pick_idx;
            pay_q   <= sel_pay_c;
            state_q <= ST_PUSH_D;
          end
        end
        ST_PUSH_D: begin
          if (!mem_wr_full) begin
            wr_en_q <= 1'b1;
            state_q <= ST_PUSH_C;
          end
        end
        ST_PUSH_C: begin
          if (!mem_cmd_full) begin
            cmd_en_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drained_c || timeout_c) begin
            done_q[grant_q] <= 1'b1;
            state_q         <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error: MCB write FIFO faults in any state, or a drain timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (mem_wr_underrun || mem_wr_error || timeout_c) begin
      err_q <= 1'b1;
    end
  end

  assign done              = done_q;
  assign err               = err_q;
  assign mem_cmd_en        = cmd_en_q;
  assign mem_cmd_instr     = INSTR_W'(MEM_CMD_WRITE);
  assign mem_cmd_bl        = '0;
  assign mem_cmd_byte_addr = pay_q.addr;
  assign mem_wr_en         = wr_en_q;
  assign mem_wr_mask       = pay_q.mask;
  assign mem_wr_data       = pay_q.data;

endmodule
